// File: rtl/pc_pkg.sv
// Shared widths, FSM states and redirect-select encoding for the PC fetch unit.
package pc_pkg;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned PC_INC = 4;
  localparam int unsigned JSH_W  = 28;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_J, SEL_JR} sel_t;
endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC target formation with jr > jump > branch > sequential priority.
module pc_target_mux
  import pc_pkg::*;
(
  input  logic [PC_W-1:0]  pc_plus4,
  input  logic             branch,
  input  logic             jump,
  input  logic             jr,
  input  logic [JSH_W-1:0] jump_sh,
  input  logic [PC_W-1:0]  branch_off,
  input  logic [PC_W-1:0]  jr_addr,
  output logic [PC_W-1:0]  target_c,
  output logic             redirect_c,
  output logic             misalign_c
);
  sel_t sel;

  always_comb begin
    sel        = SEL_SEQ;
    target_c   = pc_plus4;
    misalign_c = 1'b0;
    if (jr) begin
      sel        = SEL_JR;
      target_c   = {jr_addr[PC_W-1:2], 2'b00};
      misalign_c = |jr_addr[1:0];
    end else if (jump) begin
      sel      = SEL_J;
      target_c = {pc_plus4[PC_W-1:JSH_W], jump_sh};
    end else if (branch) begin
      sel      = SEL_BR;
      target_c = pc_plus4 + branch_off;
    end
  end

  assign redirect_c = (sel != SEL_SEQ);
endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with stall hold and a pending-redirect buffer released on unstall.
// Optional PC_STATS_EN adds saturating redirect and stall counters.
module pc_fetch_unit #(
  parameter int unsigned         PC_W     = 32,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             jr_i,
  input  logic [27:0]      jump_sh_i,
  input  logic [PC_W-1:0]  branch_off_i,
  input  logic [PC_W-1:0]  jr_addr_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pc_plus4_o,
  output logic             valid_o,
  output logic             flush_o,
`ifdef PC_STATS_EN
  output logic [15:0]      redirect_cnt_o,
  output logic [15:0]      stall_cnt_o,
`endif
  output logic             misalign_o
);
  import pc_pkg::*;

  state_t          state, state_d;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pend, pend_d;
  logic            pend_valid, pend_valid_d;
  logic            flush_d, misalign_d;
  logic [PC_W-1:0] target;
  logic            redirect, tgt_misalign;

  assign pc_plus4_o = pc_o + PC_W'(PC_INC);

  pc_target_mux u_mux (
    .pc_plus4   (pc_plus4_o),
    .branch     (branch_i),
    .jump       (jump_i),
    .jr         (jr_i),
    .jump_sh    (jump_sh_i),
    .branch_off (branch_off_i),
    .jr_addr    (jr_addr_i),
    .target_c   (target),
    .redirect_c (redirect),
    .misalign_c (tgt_misalign)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= BOOT;
      pc_o       <= RESET_PC;
      pend       <= '0;
      pend_valid <= 1'b0;
      valid_o    <= 1'b0;
      flush_o    <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_d;
      pc_o       <= pc_d;
      pend       <= pend_d;
      pend_valid <= pend_valid_d;
      valid_o    <= (state_d != BOOT);
      flush_o    <= flush_d;
      misalign_o <= misalign_d;
    end
  end

  // Stalls park the newest redirect; release prefers a fresh redirect over the parked one.
  always_comb begin
    state_d      = state;
    pc_d         = pc_o;
    pend_d       = pend;
    pend_valid_d = pend_valid;
    flush_d      = 1'b0;
    misalign_d   = 1'b0;
    case (state)
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        if (stall_i) begin
          state_d = HOLD;
          if (redirect) begin
            pend_d       = target;
            pend_valid_d = 1'b1;
            misalign_d   = tgt_misalign;
          end
        end else begin
          state_d      = RUN;
          pend_valid_d = 1'b0;
          if (redirect) begin
            pc_d       = target;
            flush_d    = 1'b1;
            misalign_d = tgt_misalign;
          end else if (pend_valid) begin
            pc_d    = pend;
            flush_d = 1'b1;
          end else begin
            pc_d = pc_plus4_o;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

`ifdef PC_STATS_EN
  logic [CNT_W-1:0] redirect_cnt, stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (flush_d && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (stall_i && (state != BOOT) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign redirect_cnt_o = redirect_cnt;
  assign stall_cnt_o    = stall_cnt;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector table plus randomized run against a behavioural next-PC model.
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst, stall, br, jmp, jr;
  logic [27:0] jsh;
  logic [31:0] boff, jra;
  logic [31:0] pc, pc4;
  logic        valid, flush, mis;
`ifdef PC_STATS_EN
  logic [15:0] rcnt, scnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_W(32), .RESET_PC(RST_PC)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .branch_i     (br),
    .jump_i       (jmp),
    .jr_i         (jr),
    .jump_sh_i    (jsh),
    .branch_off_i (boff),
    .jr_addr_i    (jra),
    .pc_o         (pc),
    .pc_plus4_o   (pc4),
    .valid_o      (valid),
    .flush_o      (flush),
`ifdef PC_STATS_EN
    .redirect_cnt_o (rcnt),
    .stall_cnt_o    (scnt),
`endif
    .misalign_o   (mis)
  );

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_boot, m_valid, m_flush, m_mis;
  logic [31:0] m_pend[$];
  int          m_rcnt, m_scnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic        has, misal;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RST_PC; m_boot = 1; m_valid = 0; m_flush = 0; m_mis = 0;
      m_pend.delete(); m_rcnt = 0; m_scnt = 0;
    end else if (m_boot) begin
      m_boot = 0; m_valid = 1; m_flush = 0; m_mis = 0;
    end else begin
      has = 1; misal = 0; tgt = 0;
      if (jr) begin
        tgt = jra & 32'hFFFF_FFFC;
        misal = (jra % 4) != 0;
      end else if (jmp) tgt = ((m_pc + 4) & 32'hF000_0000) | {4'h0, jsh};
      else if (br) tgt = m_pc + 4 + boff;
      else has = 0;
      if (stall) begin
        if (has) begin m_pend.delete(); m_pend.push_back(tgt); end
        m_flush = 0;
        m_mis = misal;
        if (m_scnt < 65535) m_scnt++;
      end else begin
        if (has) begin m_pc = tgt; m_flush = 1; end
        else if (m_pend.size() > 0) begin m_pc = m_pend[0]; m_flush = 1; end
        else begin m_pc = m_pc + 4; m_flush = 0; end
        m_pend.delete();
        m_mis = misal;
        if (m_flush && m_rcnt < 65535) m_rcnt++;
      end
    end
  endtask

  task automatic step(input logic r, s, b, j, jj, input logic [27:0] sh,
                      input logic [31:0] bo, ja);
    rst = r; stall = s; br = b; jmp = j; jr = jj; jsh = sh; boff = bo; jra = ja;
    model_edge();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("pc_plus4", pc4, m_pc + 32'd4);
    check("valid", 32'(valid), 32'(m_valid));
    check("flush", 32'(flush), 32'(m_flush));
    check("misalign", 32'(mis), 32'(m_mis));
`ifdef PC_STATS_EN
    check("redirect_cnt", 32'(rcnt), 32'(m_rcnt));
    check("stall_cnt", 32'(scnt), 32'(m_scnt));
`endif
  endtask

  typedef struct {
    logic        r, s, b, j, jj;
    logic [27:0] sh;
    logic [31:0] bo, ja;
    logic [31:0] e_pc;
    logic        e_valid, e_flush, e_mis;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, s, b, j, jj, input logic [27:0] sh,
                     input logic [31:0] bo, ja, e_pc, input logic ev, ef, em);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.j = j; v.jj = jj; v.sh = sh; v.bo = bo; v.ja = ja;
    v.e_pc = e_pc; v.e_valid = ev; v.e_flush = ef; v.e_mis = em;
    tv.push_back(v);
  endtask

  initial begin
    rst = 1; stall = 0; br = 0; jmp = 0; jr = 0; jsh = '0; boff = '0; jra = '0;
    m_pc = RST_PC; m_boot = 1; m_valid = 0; m_flush = 0; m_mis = 0; m_rcnt = 0; m_scnt = 0;

    //   r s b j jr  jsh        boff   jra            exp_pc        v f m
    add(1,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0040_0000, 0,0,0);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0040_0000, 1,0,0);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0040_0004, 1,0,0);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0040_0008, 1,0,0);
    add(0,0,0,0,1, 28'h0,    32'h0,  32'h1000_0010, 32'h1000_0010, 1,1,0);
    add(0,0,0,1,0, 28'h100,  32'h0,  32'h0,         32'h1000_0100, 1,1,0);
    add(0,0,1,1,0, 28'h200,  32'h8,  32'h0,         32'h1000_0200, 1,1,0);
    add(0,0,1,1,1, 28'h200,  32'h8,  32'h2000_0003, 32'h2000_0000, 1,1,1);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h2000_0004, 1,0,0);
    add(0,0,0,0,1, 28'h0,    32'h0,  32'h0000_0100, 32'h0000_0100, 1,1,0);
    add(0,1,1,0,0, 28'h0,    32'h20, 32'h0,         32'h0000_0100, 1,0,0);
    add(0,1,0,1,0, 28'h400,  32'h0,  32'h0,         32'h0000_0100, 1,0,0);
    add(0,1,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0000_0100, 1,0,0);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0000_0400, 1,1,0);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0000_0404, 1,0,0);
    add(0,1,1,0,0, 28'h0,    32'h10, 32'h0,         32'h0000_0404, 1,0,0);
    add(0,0,0,0,1, 28'h0,    32'h0,  32'h3000_0000, 32'h3000_0000, 1,1,0);
    add(0,1,0,1,0, 28'h80,   32'h0,  32'h0,         32'h3000_0000, 1,0,0);
    add(1,1,0,1,0, 28'h80,   32'h0,  32'h0,         32'h0040_0000, 0,0,0);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0040_0000, 1,0,0);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0040_0004, 1,0,0);
    add(0,0,0,0,1, 28'h0,    32'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,1,0);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0000_0000, 1,0,0);
    add(0,1,0,0,1, 28'h0,    32'h0,  32'h0000_0105, 32'h0000_0000, 1,0,1);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0000_0104, 1,1,0);
    add(1,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0040_0000, 0,0,0);
    add(0,0,0,1,0, 28'h800,  32'h0,  32'h0,         32'h0040_0000, 1,0,0);
    add(0,0,0,0,0, 28'h0,    32'h0,  32'h0,         32'h0040_0004, 1,0,0);

    @(negedge clk);
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].s, tv[i].b, tv[i].j, tv[i].jj, tv[i].sh, tv[i].bo, tv[i].ja);
      check($sformatf("vec%0d_pc", i), pc, tv[i].e_pc);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(tv[i].e_valid));
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'(tv[i].e_flush));
      check($sformatf("vec%0d_misalign", i), 32'(mis), 32'(tv[i].e_mis));
    end

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rb;
      rb = $urandom;
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 10), {rb[25:0], 2'b00},
           {{20{rb[13]}}, rb[11:2], 2'b00}, $urandom);
    end

`ifdef PC_STATS_EN
    step(1, 0, 0, 0, 0, 28'h0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 28'h0, 32'h0, 32'h0);
    for (int n = 0; n < 70000; n++) step(0, 1, 0, 0, 0, 28'h0, 32'h0, 32'h0);
    check("stall_cnt_sat", 32'(scnt), 32'h0000_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Registered program counter and next-PC selection for the single-cycle MIPS datapath.
- Consumes the 28-bit shifted jump field from the jump-shift stage and forms the jump target.
- Also forms branch and jump-register targets and drives the instruction-memory address.
- Holds the PC under stall; buffers a redirect that arrives during a stall until the stall releases.

Parameters:
- PC_W, 32, PC width; only 32 is supported.
- RESET_PC, 32'h0000_0000, PC value loaded by reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  hold PC this cycle
- branch_i  in  1  branch taken
- jump_i  in  1  j/jal
- jr_i  in  1  jump register
- jump_sh_i  in  28  {instr[25:0], 2'b00} from the jump-shift stage
- branch_off_i  in  32  sign-extended immediate, already shifted left 2
- jr_addr_i  in  32  rs register value
- pc_o  out  32  current PC / instruction address
- pc_plus4_o  out  32  pc_o + 4, combinational from pc_o
- valid_o  out  1  pc_o is a fetchable address
- flush_o  out  1  one-cycle pulse: pc_o was just redirected
- misalign_o  out  1  one-cycle pulse: jr target had nonzero bits [1:0]

Behaviour:
- Reset (rst_i=1 at an edge):
  - pc_o=RESET_PC, valid_o=0, flush_o=0, misalign_o=0.
  - Pending redirect cleared; state=BOOT.
  - Reset overrides every other input, including mid-stall and with a redirect pending.
- State machine:
  - BOOT -> RUN unconditionally after one cycle. During BOOT, pc_o holds and valid_o=0.
  - RUN -> HOLD when stall_i=1.
  - HOLD -> RUN when stall_i=0.
  - valid_o=1 in RUN and HOLD.
- Target arithmetic (modulo 2^32, wrap silently):
  - seq = pc_o+4
  - br = pc_plus4_o + branch_off_i
  - j = {pc_plus4_o[31:28], jump_sh_i}
  - jr = {jr_addr_i[31:2], 2'b00}
- Redirect priority when several are asserted: jr_i > jump_i > branch_i > sequential.
- RUN with stall_i=0: next edge loads the selected target into pc_o. flush_o=1 in the following cycle iff a redirect was taken.
- Stall with a redirect request (any state except BOOT):
  - pc_o holds; the redirect target is latched into the pending register.
  - A later redirect during the same stall overwrites the pending target (newest wins).
- Stall release (edge where stall_i=0):
  - If a fresh redirect is asserted, it wins over the pending one.
  - Otherwise the pending target is loaded.
  - Otherwise seq is loaded.
  - Pending is cleared. flush_o pulses if either redirect was applied.
- Redirects presented during BOOT are ignored.
- misalign_o: registered pulse on the edge where a jr redirect is selected (or latched) with jr_addr_i[1:0] != 0. The PC still loads the masked target.
- Latency: one clock from request to the new pc_o. flush_o and misalign_o are registered and aligned with the new pc_o.

Optional Feature:
- Macro PC_STATS_EN.
- Defined:
  - Adds outputs redirect_cnt_o[15:0] and stall_cnt_o[15:0].
  - Both are saturating counters: applied redirects, and cycles with stall_i=1 outside BOOT.
  - Both reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package pc_pkg holds:
  - PC_W
  - PC_INC (4)
  - state enum {BOOT, RUN, HOLD}
  - redirect-select enum {SEL_SEQ, SEL_BR, SEL_J, SEL_JR}
- Sub-module pc_target_mux (combinational):
  - Computes seq/br/j/jr and the priority select.
  - Outputs the target plus a misalign flag.
- The top level holds the PC register, pending buffer, FSM and pulses.

Test Plan:
- Reset with RESET_PC=0x0040_0000, run 3 idle cycles -> pc_o: 0x00400000 (valid_o=0), 0x00400000 (valid_o=1), 0x00400004, 0x00400008.
- pc_o=0x1000_0010, jump_i=1, jump_sh_i=0x0000_0100 -> next pc_o=0x1000_0100, flush_o=1 for one cycle.
- Same cycle jump_i=1, branch_i=1, branch_off_i=0x8 -> jump target taken; repeat with jr_i=1, jr_addr_i=0x2000_0003 -> pc_o=0x2000_0000, misalign_o=1.
- Stall 3 cycles from pc_o=0x100:
  - branch_off_i=0x20 in stall cycle 1, jump in stall cycle 2 -> pc_o holds 0x100.
  - On release, pc_o = jump target and flush_o=1.
- Stall release with pending branch and fresh jr -> jr target loaded; rst_i asserted with a redirect pending -> pc_o=RESET_PC and pending lost (no flush after reset).
- pc_o=0xFFFF_FFFC, sequential -> pc_o=0x0000_0000; with PC_STATS_EN, 70000 stall cycles -> stall_cnt_o=0xFFFF.
